veriyolu_denetim: RTL and testbench
===================================

Name: veriyolu_denetim

Overview:
Control sequencer for the veriyolu datapath. It is the initiator that drives the datapath's bus-enable masks, register load strobes and ALU select, so the datapath no longer needs hand-written stimulus. It accepts one ALU command per valid/ready handshake and steps the datapath through S1->A, S2->B, ALU->AR and optional AR->memory. It reports completion with a one-cycle pulse.

Parameters:
DW, 8, datapath word width; all *_yolla masks are DW bits.
PHASE_CYC, 2, cycles each phase is held (legal 1..15).

Ports:
aclk  in  1  clock, all state on rising edge
arst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  3  ALU operation, forwarded to alu_sel
cmd_wr  in  1  1 = write AR result to memory after execution
iptal  in  1  synchronous abort
alu_sel  out  3  datapath ALU select
s1_yolla  out  DW  drive S1 onto bus (all-ones/all-zeros)
s2_yolla  out  DW  drive S2 onto bus
a_yolla  out  DW  drive A onto bus (always 0 in this version)
b_yolla  out  DW  drive B onto bus (always 0 in this version)
ar_yolla  out  DW  drive AR onto bus
a_yukle  out  1  load A from bus
b_yukle  out  1  load B from bus
ar_yukle  out  1  load AR from ALU result
mem_we  out  1  memory write strobe (to_memory/m_address valid)
done  out  1  one-cycle completion pulse
islem_sayisi  out  8  count of completed commands

Behaviour:
- All outputs registered. arst forces state IDLE, every output 0, phase counter 0, latched op/wr 0, islem_sayisi 0. It acts immediately and regardless of aclk.
- States: IDLE, P_S1A, P_S2B, P_EXEC, P_OUT, DONE.
- IDLE: cmd_ready=1, all strobes/masks 0. Accept when cmd_valid&cmd_ready at a rising edge. Latch cmd_op and cmd_wr, then go to P_S1A. Later changes on cmd_* are ignored until the next acceptance.
- P_S1A: s1_yolla=all-ones, a_yukle=1.
- P_S2B: s2_yolla=all-ones, b_yukle=1, alu_sel=op.
- P_EXEC: alu_sel=op, ar_yukle=1, all masks 0.
- P_OUT: entered only if wr=1. ar_yolla=all-ones, mem_we=1, alu_sel=op. If wr=0, P_EXEC goes directly to DONE.
- Each P_* state holds exactly PHASE_CYC cycles, counted by the phase counter, which clears on every state change.
- DONE: one cycle. done=1, cmd_ready=0, islem_sayisi+1 (wraps 255->0), all strobes 0. Next state IDLE.
- Bus exclusivity invariant: at most one *_yolla is nonzero in any cycle. Masks are only 0 or all-ones. Phase transitions switch drivers on the same edge with no overlap.
- Latency with PHASE_CYC=N, acceptance at edge 0:
  - P_S1A is cycles 1..N, P_S2B is N+1..2N, P_EXEC is 2N+1..3N.
  - P_OUT is 3N+1..4N when wr=1.
  - done is at cycle 4N+1 (wr=1) or 3N+1 (wr=0).
  - cmd_ready returns the cycle after done.
- iptal=1 in any non-IDLE state: the next edge goes to IDLE with all outputs 0. No done pulse, islem_sayisi unchanged, in-flight command discarded. iptal in IDLE has no effect, and acceptance in that cycle is still allowed.
- iptal and arst together: arst wins.
- arst mid-command: immediate return to reset values; the command is lost.
- alu_sel is 0 in IDLE, P_S1A and DONE.

Test Plan:
1. Reset: arst=1 for 2 cycles mid-P_S2B -> all outputs 0 immediately, cmd_ready=1 after release, islem_sayisi=0.
2. cmd_op=3'b101, cmd_wr=1, N=2 -> s1_yolla=FF/a_yukle in cycles 1-2; s2_yolla=FF/b_yukle/alu_sel=5 in cycles 3-4; ar_yukle in cycles 5-6; ar_yolla=FF/mem_we in cycles 7-8; done in cycle 9; islem_sayisi=1.
3. cmd_wr=0, cmd_op=3'b010 -> no P_OUT, mem_we never 1, done in cycle 7; back-to-back valid is accepted in cycle 8.
4. iptal asserted in cycle 4 of a command -> all outputs 0 from cycle 5, no done, islem_sayisi unchanged, cmd_ready=1 in cycle 5.
5. Every-cycle checker over 256+ random commands (random valid, iptal, N=1 build) -> at most one nonzero *_yolla, masks in {00,FF}, islem_sayisi wraps 255->0.
6. cmd_valid held high with cmd_op changing during execution -> latched op is unchanged on alu_sel until done.

Source files
------------

// File: rtl/veriyolu_denetim.sv
// veriyolu_denetim: command sequencer that steps the veriyolu datapath
// through S1->A, S2->B, ALU->AR and an optional AR->memory phase.
module veriyolu_denetim #(
    parameter int DW        = 8,
    parameter int PHASE_CYC = 2
) (
    input  logic          aclk,
    input  logic          arst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic          cmd_wr,
    input  logic          iptal,
    output logic [2:0]    alu_sel,
    output logic [DW-1:0] s1_yolla,
    output logic [DW-1:0] s2_yolla,
    output logic [DW-1:0] a_yolla,
    output logic [DW-1:0] b_yolla,
    output logic [DW-1:0] ar_yolla,
    output logic          a_yukle,
    output logic          b_yukle,
    output logic          ar_yukle,
    output logic          mem_we,
    output logic          done,
    output logic [7:0]    islem_sayisi
);

    typedef enum logic [2:0] {
        IDLE,
        P_S1A,
        P_S2B,
        P_EXEC,
        P_OUT,
        DONE
    } state_e;

    localparam logic [3:0]    CNT_LAST = 4'(PHASE_CYC - 1);
    localparam logic [DW-1:0] ONES     = '1;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic          wr_q, wr_d;
    logic          ready_q, ready_d;
    logic [2:0]    alu_q, alu_d;
    logic [DW-1:0] s1_q, s1_d;
    logic [DW-1:0] s2_q, s2_d;
    logic [DW-1:0] ar_q, ar_d;
    logic          ay_q, ay_d;
    logic          by_q, by_d;
    logic          ary_q, ary_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic [7:0]    sayi_q, sayi_d;
    logic          phase_end;

    assign phase_end = (cnt_q == CNT_LAST);

    // Next state, then outputs decoded from the next state so they are registered
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wr_d    = wr_q;
        cnt_d   = '0;
        ready_d = 1'b0;
        alu_d   = '0;
        s1_d    = '0;
        s2_d    = '0;
        ar_d    = '0;
        ay_d    = 1'b0;
        by_d    = 1'b0;
        ary_d   = 1'b0;
        we_d    = 1'b0;
        done_d  = 1'b0;
        sayi_d  = sayi_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d    = cmd_op;
                    wr_d    = cmd_wr;
                    state_d = P_S1A;
                end
            end
            P_S1A:   if (phase_end) state_d = P_S2B;
            P_S2B:   if (phase_end) state_d = P_EXEC;
            P_EXEC:  if (phase_end) state_d = wr_q ? P_OUT : DONE;
            P_OUT:   if (phase_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (iptal && state_q != IDLE) begin
            state_d = IDLE;
        end

        if (state_d == state_q && state_q != IDLE && state_q != DONE) begin
            cnt_d = cnt_q + 4'd1;
        end

        unique case (state_d)
            IDLE:    ready_d = 1'b1;
            P_S1A: begin
                s1_d = ONES;
                ay_d = 1'b1;
            end
            P_S2B: begin
                s2_d  = ONES;
                by_d  = 1'b1;
                alu_d = op_d;
            end
            P_EXEC: begin
                ary_d = 1'b1;
                alu_d = op_d;
            end
            P_OUT: begin
                ar_d  = ONES;
                we_d  = 1'b1;
                alu_d = op_d;
            end
            DONE: begin
                done_d = 1'b1;
                sayi_d = sayi_q + 8'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            alu_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            ar_q    <= '0;
            ay_q    <= 1'b0;
            by_q    <= 1'b0;
            ary_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            sayi_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            alu_q   <= alu_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            ar_q    <= ar_d;
            ay_q    <= ay_d;
            by_q    <= by_d;
            ary_q   <= ary_d;
            we_q    <= we_d;
            done_q  <= done_d;
            sayi_q  <= sayi_d;
        end
    end

    assign cmd_ready    = ready_q;
    assign alu_sel      = alu_q;
    assign s1_yolla     = s1_q;
    assign s2_yolla     = s2_q;
    assign a_yolla      = '0;
    assign b_yolla      = '0;
    assign ar_yolla     = ar_q;
    assign a_yukle      = ay_q;
    assign b_yukle      = by_q;
    assign ar_yukle     = ary_q;
    assign mem_we       = we_q;
    assign done         = done_q;
    assign islem_sayisi = sayi_q;

endmodule

// File: tb/tb_veriyolu_denetim.sv
// Directed and randomized checks for veriyolu_denetim
// (PHASE_CYC=2 instance for timelines, PHASE_CYC=1 instance for random run).
module tb_veriyolu_denetim;

    logic       aclk = 1'b0;
    logic       arst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = '0;
    logic       cmd_wr = 1'b0;
    logic       iptal = 1'b0;
    logic       cmd_ready, a_yukle, b_yukle, ar_yukle, mem_we, done;
    logic [2:0] alu_sel;
    logic [7:0] s1_yolla, s2_yolla, a_yolla, b_yolla, ar_yolla, islem_sayisi;

    logic       arst1 = 1'b1;
    logic       valid1 = 1'b0;
    logic [2:0] op1 = '0;
    logic       wr1 = 1'b0;
    logic       iptal1 = 1'b0;
    logic       ready1, ay1, by1, ary1, we1, done1;
    logic [2:0] alu1;
    logic [7:0] s1m1, s2m1, am1, bm1, arm1, sayi1;

    int passed = 0;
    int total = 0;
    logic [7:0] exp_cnt = '0;

    logic [48:0] obs0, obs1;
    assign obs0 = {cmd_ready, alu_sel, s1_yolla, s2_yolla, a_yolla, b_yolla,
                   ar_yolla, a_yukle, b_yukle, ar_yukle, mem_we, done};
    assign obs1 = {ready1, alu1, s1m1, s2m1, am1, bm1, arm1,
                   ay1, by1, ary1, we1, done1};

    veriyolu_denetim #(.DW(8), .PHASE_CYC(2)) dut (
        .aclk(aclk), .arst(arst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_wr(cmd_wr), .iptal(iptal), .alu_sel(alu_sel),
        .s1_yolla(s1_yolla), .s2_yolla(s2_yolla), .a_yolla(a_yolla),
        .b_yolla(b_yolla), .ar_yolla(ar_yolla), .a_yukle(a_yukle),
        .b_yukle(b_yukle), .ar_yukle(ar_yukle), .mem_we(mem_we), .done(done),
        .islem_sayisi(islem_sayisi)
    );

    veriyolu_denetim #(.DW(8), .PHASE_CYC(1)) dut1 (
        .aclk(aclk), .arst(arst1), .cmd_valid(valid1), .cmd_ready(ready1),
        .cmd_op(op1), .cmd_wr(wr1), .iptal(iptal1), .alu_sel(alu1),
        .s1_yolla(s1m1), .s2_yolla(s2m1), .a_yolla(am1),
        .b_yolla(bm1), .ar_yolla(arm1), .a_yukle(ay1),
        .b_yukle(by1), .ar_yukle(ary1), .mem_we(we1), .done(done1),
        .islem_sayisi(sayi1)
    );

    always #5 aclk = ~aclk;

    // Phase codes: 0 idle, 1 S1A, 2 S2B, 3 EXEC, 4 OUT, 5 DONE, 6 all zero
    function automatic logic [48:0] exp_out(int ph, logic [2:0] op);
        logic       rdy = 1'b0;
        logic [2:0] alu = '0;
        logic [7:0] s1 = '0, s2 = '0, ar = '0;
        logic       ay = 1'b0, by = 1'b0, ary = 1'b0, we = 1'b0, dn = 1'b0;
        case (ph)
            0: rdy = 1'b1;
            1: begin s1 = 8'hFF; ay = 1'b1; end
            2: begin s2 = 8'hFF; by = 1'b1; alu = op; end
            3: begin ary = 1'b1; alu = op; end
            4: begin ar = 8'hFF; we = 1'b1; alu = op; end
            5: dn = 1'b1;
            default: ;
        endcase
        return {rdy, alu, s1, s2, 8'h00, 8'h00, ar, ay, by, ary, we, dn};
    endfunction

    // Hand timeline for PHASE_CYC=2, cycle c after acceptance
    function automatic int ph_of(int c, logic wr);
        if (c <= 2) return 1;
        if (c <= 4) return 2;
        if (c <= 6) return 3;
        if (wr && c <= 8) return 4;
        if (c == (wr ? 9 : 7)) return 5;
        return 0;
    endfunction

    task automatic start_cmd(input logic [2:0] op, input logic wr);
        int w = 0;
        @(negedge aclk);
        while (!cmd_ready && w < 50) begin
            @(negedge aclk);
            w++;
        end
        if (!cmd_ready) begin
            total++;
            $display("FAIL start_timeout cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_wr    = wr;
        @(posedge aclk);
    endtask

    task automatic test_reset();
        @(negedge aclk);
        total++;
        if (obs0 !== exp_out(6, 3'd0) || islem_sayisi !== 8'd0)
            $display("FAIL reset_state got %h/%0d required %h/0",
                     obs0, islem_sayisi, exp_out(6, 3'd0));
        else passed++;
        arst = 1'b0;
        @(negedge aclk);
        total++;
        if (obs0 !== exp_out(0, 3'd0))
            $display("FAIL reset_release got %h required %h", obs0, exp_out(0, 3'd0));
        else passed++;
        start_cmd(3'd7, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge aclk);
            if (c == 1) cmd_valid = 1'b0;
        end
        total++;
        if (obs0 !== exp_out(2, 3'd7))
            $display("FAIL reset_pre_s2b got %h required %h", obs0, exp_out(2, 3'd7));
        else passed++;
        #2 arst = 1'b1;
        #1;
        total++;
        if (obs0 !== exp_out(6, 3'd0))
            $display("FAIL reset_async got %h required %h", obs0, exp_out(6, 3'd0));
        else passed++;
        @(negedge aclk);
        @(negedge aclk);
        total++;
        if (obs0 !== exp_out(6, 3'd0))
            $display("FAIL reset_hold got %h required %h", obs0, exp_out(6, 3'd0));
        else passed++;
        arst = 1'b0;
        @(negedge aclk);
        total++;
        if (obs0 !== exp_out(0, 3'd0) || islem_sayisi !== 8'd0)
            $display("FAIL reset_after got %h/%0d required %h/0",
                     obs0, islem_sayisi, exp_out(0, 3'd0));
        else passed++;
    endtask

    task automatic test_write_cmd();
        start_cmd(3'b101, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge aclk);
            if (c == 1) cmd_valid = 1'b0;
            total++;
            if (obs0 !== exp_out(ph_of(c, 1'b1), 3'b101))
                $display("FAIL write_c%0d got %h required %h",
                         c, obs0, exp_out(ph_of(c, 1'b1), 3'b101));
            else passed++;
        end
        exp_cnt = exp_cnt + 8'd1;
        total++;
        if (islem_sayisi !== exp_cnt)
            $display("FAIL write_count got %0d required %0d", islem_sayisi, exp_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic we_seen = 1'b0;
        start_cmd(3'b010, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge aclk);
            if (c == 1) cmd_valid = 1'b0;
            we_seen = we_seen | mem_we;
            total++;
            if (obs0 !== exp_out(ph_of(c, 1'b0), 3'b010))
                $display("FAIL nowr_c%0d got %h required %h",
                         c, obs0, exp_out(ph_of(c, 1'b0), 3'b010));
            else passed++;
            if (c == 7) begin
                cmd_valid = 1'b1;
                cmd_op    = 3'b011;
                cmd_wr    = 1'b0;
            end
        end
        exp_cnt = exp_cnt + 8'd1;
        total++;
        if (we_seen !== 1'b0)
            $display("FAIL nowr_mem_we got %b required 0", we_seen);
        else passed++;
        for (int c = 1; c <= 8; c++) begin
            @(negedge aclk);
            if (c == 1) cmd_valid = 1'b0;
            total++;
            if (obs0 !== exp_out(ph_of(c, 1'b0), 3'b011))
                $display("FAIL b2b_c%0d got %h required %h",
                         c, obs0, exp_out(ph_of(c, 1'b0), 3'b011));
            else passed++;
        end
        exp_cnt = exp_cnt + 8'd1;
        total++;
        if (islem_sayisi !== exp_cnt)
            $display("FAIL b2b_count got %0d required %0d", islem_sayisi, exp_cnt);
        else passed++;
    endtask

    task automatic test_abort();
        start_cmd(3'b001, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge aclk);
            if (c == 1) cmd_valid = 1'b0;
        end
        total++;
        if (obs0 !== exp_out(2, 3'b001))
            $display("FAIL abort_c4 got %h required %h", obs0, exp_out(2, 3'b001));
        else passed++;
        iptal = 1'b1;
        @(negedge aclk);
        iptal = 1'b0;
        for (int c = 5; c <= 12; c++) begin
            total++;
            if (obs0 !== exp_out(0, 3'd0) || islem_sayisi !== exp_cnt)
                $display("FAIL abort_c%0d got %h/%0d required %h/%0d",
                         c, obs0, islem_sayisi, exp_out(0, 3'd0), exp_cnt);
            else passed++;
            @(negedge aclk);
        end
    endtask

    task automatic test_op_hold();
        start_cmd(3'b110, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge aclk);
            total++;
            if (obs0 !== exp_out(ph_of(c, 1'b1), 3'b110))
                $display("FAIL ophold_c%0d got %h required %h",
                         c, obs0, exp_out(ph_of(c, 1'b1), 3'b110));
            else passed++;
            cmd_op = 3'(c);
            cmd_wr = c[0];
            if (c >= 9) cmd_valid = 1'b0;
        end
        exp_cnt = exp_cnt + 8'd1;
        total++;
        if (islem_sayisi !== exp_cnt)
            $display("FAIL ophold_count got %0d required %0d", islem_sayisi, exp_cnt);
        else passed++;
    endtask

    task automatic test_random();
        int m_st = 0;
        int nst;
        int m_total = 0;
        int nz;
        logic [2:0] m_op = '0;
        logic m_wr = 1'b0;
        logic [7:0] m_cnt = '0;
        logic mask_ok;
        @(negedge aclk);
        arst1 = 1'b0;
        for (int cyc = 0; cyc < 6000 && m_total < 260; cyc++) begin
            @(negedge aclk);
            total++;
            if (obs1 !== exp_out(m_st, m_op) || sayi1 !== m_cnt)
                $display("FAIL rand_model cyc%0d got %h/%0d required %h/%0d",
                         cyc, obs1, sayi1, exp_out(m_st, m_op), m_cnt);
            else passed++;
            nz = int'(s1m1 != 0) + int'(s2m1 != 0) + int'(am1 != 0)
               + int'(bm1 != 0) + int'(arm1 != 0);
            mask_ok = (s1m1 == 8'h00 || s1m1 == 8'hFF)
                   && (s2m1 == 8'h00 || s2m1 == 8'hFF)
                   && (am1 == 8'h00 || am1 == 8'hFF)
                   && (bm1 == 8'h00 || bm1 == 8'hFF)
                   && (arm1 == 8'h00 || arm1 == 8'hFF);
            total++;
            if (nz > 1 || !mask_ok)
                $display("FAIL rand_bus cyc%0d drivers=%0d masks_ok=%b required <=1/1",
                         cyc, nz, mask_ok);
            else passed++;
            valid1 = ($urandom_range(3) != 0);
            op1    = 3'($urandom);
            wr1    = 1'($urandom);
            iptal1 = ($urandom_range(15) == 0);
            case (m_st)
                0: nst = valid1 ? 1 : 0;
                1: nst = 2;
                2: nst = 3;
                3: nst = m_wr ? 4 : 5;
                4: nst = 5;
                default: nst = 0;
            endcase
            if (iptal1 && m_st != 0) nst = 0;
            if (m_st == 0 && nst == 1) begin
                m_op = op1;
                m_wr = wr1;
            end
            if (nst == 5) begin
                m_cnt = m_cnt + 8'd1;
                m_total++;
            end
            m_st = nst;
        end
        total++;
        if (m_total < 260)
            $display("FAIL rand_budget completions=%0d required 260", m_total);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write_cmd();
        test_back_to_back();
        test_abort();
        test_op_hold();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
